seq_detect_ctrl: RTL and testbench

Programmable serial pattern-detection controller.
- Accepts a pattern configuration through a valid/ready handshake.
- Arms on a start pulse, scans serial input X one bit per clock, and pulses Y on each match.
- Counts matches and terminates on a programmable match target.
- Replaces the fixed-pattern overlapping/non-overlapping detectors with one configurable, sequenced engine.

---
 rtl/seq_detect_ctrl_if.sv | 25 ++
 rtl/seq_detect_ctrl.sv | 117 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - configuration bus for the pattern-detection controller
interface seq_detect_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) ();
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               cfg_err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern detector with match counting
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    seq_detect_ctrl_if.slave   cfg,
    input  logic               start,
    input  logic               abort,
    input  logic               X,
    output logic               Y,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_count
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic               cfg_ok;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [CNT_W-1:0]   count;
    logic               y_q;
    logic               err_q;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W-1:0]   count_inc;
    logic               len_legal;
    logic               hit;

    // The match test includes the bit being sampled on this edge.
    always_comb begin
        hist_nxt  = {hist[MAX_LEN-2:0], X};
        len_mask  = ~({MAX_LEN{1'b1}} << len_q);
        fill_inc  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        count_inc = (&count) ? count : count + CNT_W'(1);
        hit       = ((fill + LEN_W'(1)) >= len_q) &&
                    ((hist_nxt & len_mask) == (pat_q & len_mask));
        len_legal = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_W'(MAX_LEN));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            cfg_ok <= 1'b0;
            pat_q  <= '0;
            len_q  <= '0;
            ovl_q  <= 1'b0;
            tgt_q  <= '0;
            hist   <= '0;
            fill   <= '0;
            count  <= '0;
            y_q    <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            y_q   <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A configuration offer wins over a coincident start.
                    if (cfg.cfg_valid) begin
                        if (len_legal) begin
                            pat_q  <= cfg.cfg_pattern;
                            len_q  <= cfg.cfg_len;
                            ovl_q  <= cfg.cfg_overlap;
                            tgt_q  <= cfg.cfg_target;
                            cfg_ok <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (start && cfg_ok) begin
                        state <= S_RUN;
                        count <= '0;
                        hist  <= '0;
                        fill  <= '0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        hist <= hist_nxt;
                        if (hit) begin
                            y_q   <= 1'b1;
                            count <= count_inc;
                            fill  <= ovl_q ? fill_inc : '0;
                            if ((tgt_q != '0) && (count_inc == tgt_q))
                                state <= S_DONE;
                        end else begin
                            fill <= fill_inc;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cfg.cfg_ready = (state == S_IDLE);
    assign cfg.cfg_err   = err_q;
    assign Y             = y_q;
    assign busy          = (state == S_RUN);
    assign done          = (state == S_DONE);
    assign match_count   = count;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed scoreboard bench for seq_detect_ctrl
module tb_seq_detect_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             X     = 1'b0;
    logic             Y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;

    seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) cif ();

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg         (cif.slave),
        .start       (start),
        .abort       (abort),
        .X           (X),
        .Y           (Y),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             y;
        logic             d;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_y"},         Y,             0);
        chk({tag, "_done"},      done,          0);
        chk({tag, "_busy"},      busy,          0);
        chk({tag, "_count"},     match_count,   0);
        chk({tag, "_cfg_ready"}, cif.cfg_ready, 1);
        chk({tag, "_cfg_err"},   cif.cfg_err,   0);
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                             input logic ovl, input logic [CNT_W-1:0] tgt, input logic exp_err);
        cif.cfg_valid   = 1'b1;
        cif.cfg_pattern = pat;
        cif.cfg_len     = len;
        cif.cfg_overlap = ovl;
        cif.cfg_target  = tgt;
        tick;
        cif.cfg_valid = 1'b0;
        chk($sformatf("cfg_err_len%0d", len), cif.cfg_err, exp_err);
        if (exp_err) begin
            tick;
            chk($sformatf("cfg_err_drop_len%0d", len), cif.cfg_err, 0);
        end
    endtask

    task automatic arm(input logic exp_busy);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, exp_busy);
        if (exp_busy) model_cnt = '0;
    endtask

    task automatic stream(input logic [15:0] bits, input int n,
                          input logic [15:0] yexp, input logic [15:0] dexp);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            X = bits[i];
            if (yexp[i]) model_cnt = model_cnt + 1'b1;
            e.y   = yexp[i];
            e.d   = dexp[i];
            e.cnt = model_cnt;
            sb.push_back(e);
            tick;
            e = sb.pop_front();
            chk($sformatf("y_bit%0d", i),     Y,           e.y);
            chk($sformatf("done_bit%0d", i),  done,        e.d);
            chk($sformatf("count_bit%0d", i), match_count, e.cnt);
        end
        X = 1'b0;
    endtask

    initial begin
        cif.cfg_valid   = 1'b0;
        cif.cfg_pattern = '0;
        cif.cfg_len     = '0;
        cif.cfg_overlap = 1'b0;
        cif.cfg_target  = '0;
        tick;
        tick;
        check_idle_reset("reset");
        reset = 1'b0;

        // Illegal lengths with no prior config: errors pulse and start is ignored.
        configure(8'h00, 0, 1'b0, 0, 1'b1);
        configure(8'h00, LEN_W'(MAX_LEN + 1), 1'b0, 0, 1'b1);
        arm(1'b0);
        chk("noconfig_count", match_count, 0);

        // 0110 overlapping, free-running, ended by abort.
        configure(8'h06, 4, 1'b1, 0, 1'b0);
        arm(1'b1);
        stream(16'h666C, 16, 16'h8890, 16'h0000);
        chk("ovl_total", match_count, 4);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("ovl_abort_busy", busy, 0);
        chk("ovl_abort_ready", cif.cfg_ready, 1);
        chk("ovl_abort_count", match_count, 4);

        // Same stream non-overlapping.
        configure(8'h06, 4, 1'b0, 0, 1'b0);
        arm(1'b1);
        stream(16'h666C, 16, 16'h8810, 16'h0000);
        chk("novl_total", match_count, 3);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("novl_abort_busy", busy, 0);

        // 1011 with target 2: done coincides with the second Y.
        configure(8'h0B, 4, 1'b1, 2, 1'b0);
        arm(1'b1);
        stream(16'h006D, 7, 16'h0048, 16'h0040);
        tick;
        chk("tgt_busy", busy, 0);
        chk("tgt_ready", cif.cfg_ready, 1);
        chk("tgt_done_drop", done, 0);
        chk("tgt_y_drop", Y, 0);
        chk("tgt_count", match_count, 2);
        tick;
        chk("tgt_count_hold", match_count, 2);

        // Abort on the edge that would complete the second match.
        configure(8'h06, 4, 1'b1, 0, 1'b0);
        arm(1'b1);
        stream(16'h0036, 6, 16'h0008, 16'h0000);
        X = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_y", Y, 0);
        chk("abort_count", match_count, 1);
        chk("abort_busy", busy, 0);

        // Reset mid-run drops config and partial history.
        configure(8'h06, 4, 1'b1, 0, 1'b0);
        arm(1'b1);
        stream(16'h0006, 3, 16'h0000, 16'h0000);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_idle_reset("midrun_reset");
        arm(1'b0);
        configure(8'h06, 4, 1'b1, 0, 1'b0);
        arm(1'b1);
        stream(16'h0006, 4, 16'h0008, 16'h0000);
        chk("post_reset_count", match_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
